// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: shared skid-FSM state encodings and per-stage payload bundle widths
package pipe_stage_skid_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;
    localparam int IFU_W = 64;
    localparam int IDU_W = 96;
    localparam int EXU_W = 128;
    localparam int LSU_W = 96;
    localparam int WBU_W = 40;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: one valid/ready/data channel between pipeline stages
interface pipe_stage_skid_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master (output valid, data, input ready);
    modport slave (input valid, data, output ready);
endinterface

// File: rtl/pipe_stage_skid_ctrl.sv
// pipe_skid_ctrl: 2-entry skid FSM with registered in_ready/out_valid and payload load enables
module pipe_skid_ctrl
    import pipe_stage_skid_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic sel_skid
);
    skid_state_e state, state_nx;
    logic fire_in, fire_out;
    always_comb begin
        fire_in   = in_valid && in_ready;
        fire_out  = out_valid && out_ready;
        sel_skid  = state == ST_FULL;
        load_main = !flush && (state == ST_FULL ? fire_out :
                               state == ST_BUSY ? fire_in && fire_out : fire_in);
        load_skid = !flush && state == ST_BUSY && fire_in && !fire_out;
        state_nx  = flush ? ST_EMPTY :
                    state == ST_EMPTY ? (fire_in ? ST_BUSY : ST_EMPTY) :
                    state == ST_BUSY ? (fire_in && !fire_out ? ST_FULL :
                                        !fire_in && fire_out ? ST_EMPTY : ST_BUSY) :
                    (fire_out ? ST_BUSY : ST_FULL);
    end
    // in_ready/out_valid are decoded from the next state so both leave as flop outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= state_nx != ST_FULL;
            out_valid <= state_nx != ST_EMPTY;
        end
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage pipeline register, optional 2-entry skid, saturating stall counter
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b0,
    parameter int               CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_stage_skid_if.slave        up,
    pipe_stage_skid_if.master       dn,
    input  logic                    flush,
    output logic [CNT_W-1:0]        stall_cnt
);
    logic             load_main;
    logic [WIDTH-1:0] main_d;
    if (SKID) begin : g_skid
        logic             load_skid, sel_skid;
        logic [WIDTH-1:0] skid_q;
        pipe_skid_ctrl u_ctrl (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (up.valid),
            .out_ready (dn.ready),
            .in_ready  (up.ready),
            .out_valid (dn.valid),
            .load_main (load_main),
            .load_skid (load_skid),
            .sel_skid  (sel_skid)
        );
        always_ff @(posedge clk) begin
            if (load_skid) skid_q <= up.data;
        end
        assign main_d = sel_skid ? skid_q : up.data;
    end else begin : g_single
        logic valid_q;
        assign up.ready  = !valid_q || dn.ready;
        assign load_main = !flush && up.valid && up.ready;
        assign main_d    = up.data;
        assign dn.valid  = valid_q;
        always_ff @(posedge clk) begin
            if (rst) valid_q <= 1'b0;
            else     valid_q <= !flush && (load_main || (valid_q && !dn.ready));
        end
    end
    always_ff @(posedge clk) begin
        if (rst)            dn.data <= RESET_VAL;
        else if (load_main) dn.data <= main_d;
    end
    always_ff @(posedge clk) begin
        if (rst)                                         stall_cnt <= '0;
        else if (dn.valid && !dn.ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vectors plus a random scoreboard run on single, skid and narrow-counter stages
module tb_pipe_stage_skid;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] stall0, stall1;
    logic [2:0]  stall2;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.WIDTH(32)) i0u ();
    pipe_stage_skid_if #(.WIDTH(32)) i0d ();
    pipe_stage_skid_if #(.WIDTH(32)) i1u ();
    pipe_stage_skid_if #(.WIDTH(32)) i1d ();
    pipe_stage_skid_if #(.WIDTH(8))  i2u ();
    pipe_stage_skid_if #(.WIDTH(8))  i2d ();

    assign i0u.valid = in_valid;
    assign i0u.data  = in_data;
    assign i0d.ready = out_ready;
    assign i1u.valid = in_valid;
    assign i1u.data  = in_data;
    assign i1d.ready = out_ready;
    assign i2u.valid = in_valid;
    assign i2u.data  = in_data[7:0];
    assign i2d.ready = out_ready;

    pipe_stage_skid #(.WIDTH(32), .RESET_VAL(32'hDEAD_BEEF), .SKID(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .up(i0u), .dn(i0d), .flush(flush), .stall_cnt(stall0));
    pipe_stage_skid #(.WIDTH(32), .RESET_VAL(32'hDEAD_BEEF), .SKID(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .up(i1u), .dn(i1d), .flush(flush), .stall_cnt(stall1));
    pipe_stage_skid #(.WIDTH(8), .RESET_VAL(8'hA5), .SKID(1'b1), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .up(i2u), .dn(i2d), .flush(flush), .stall_cnt(stall2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    logic        v[3], r[3];
    logic [31:0] d[3];
    int          s[3];
    int          cnt[3], smod[3];
    logic [31:0] ent[3][2];

    initial begin
        // reset held with in_valid asserted
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b0;
        step(); step();
        chk("rst_ov0", i0d.valid, 0); chk("rst_ov1", i1d.valid, 0); chk("rst_ov2", i2d.valid, 0);
        chk("rst_od0", i0d.data, 32'hDEAD_BEEF); chk("rst_od1", i1d.data, 32'hDEAD_BEEF);
        chk("rst_od2", i2d.data, 8'hA5);
        chk("rst_st0", stall0, 0); chk("rst_st1", stall1, 0); chk("rst_st2", stall2, 0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("rst_ir0", i0u.ready, 1); chk("rst_ir1", i1u.ready, 1); chk("rst_ir2", i2u.ready, 1);

        // back-to-back stream, one-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = i;
            step();
            chk("str_ov0", i0d.valid, 1); chk("str_od0", i0d.data, i);
            chk("str_ov1", i1d.valid, 1); chk("str_od1", i1d.data, i);
            chk("str_od2", i2d.data, i);
            chk("str_ir0", i0u.ready, 1); chk("str_ir1", i1u.ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("str_end0", i0d.valid, 0); chk("str_end1", i1d.valid, 0);

        // skid fills with A,B then drains in order
        reset_dut();
        in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        chk("full_ir1", i1u.ready, 0); chk("full_ov1", i1d.valid, 1); chk("full_od1", i1d.data, 32'hA);
        chk("full_ir0", i0u.ready, 0); chk("full_od0", i0d.data, 32'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("drn_od1", i1d.data, 32'hB); chk("drn_ov1", i1d.valid, 1); chk("drn_ir1", i1u.ready, 1);
        chk("drn_ov0", i0d.valid, 0);
        step();
        chk("drn_end1", i1d.valid, 0);

        // stall with stable payload, then saturation of the 3-bit counter
        reset_dut();
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
        step();
        in_data = 32'h66;
        repeat (5) step();
        chk("stl_ir0", i0u.ready, 0); chk("stl_od0", i0d.data, 32'h55); chk("stl_ov0", i0d.valid, 1);
        chk("stl_cnt0", stall0, 5); chk("stl_cnt1", stall1, 5); chk("stl_cnt2", stall2, 5);
        chk("stl_ir1", i1u.ready, 0); chk("stl_od1", i1d.data, 32'h55);
        repeat (5) step();
        chk("sat_cnt2", stall2, 7); chk("sat_cnt0", stall0, 10); chk("sat_od0", i0d.data, 32'h55);

        // flush while full with a beat offered
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        #1;
        chk("fl_pre_ov0", i0d.valid, 1); chk("fl_pre_ov1", i1d.valid, 1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_ov1", i1d.valid, 0); chk("fl_ir1", i1u.ready, 1);
        chk("fl_ov0", i0d.valid, 0); chk("fl_ir0", i0u.ready, 1);
        chk("fl_cnt2", stall2, 7);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("fl_stale1", i1d.valid, 0); chk("fl_stale0", i0d.valid, 0);
        end

        // random valid/ready/flush against a small queue model
        reset_dut();
        for (int i = 0; i < 3; i++) begin cnt[i] = 0; smod[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = $urandom;
            @(negedge clk);
            v[0] = i0d.valid; r[0] = i0u.ready; d[0] = i0d.data; s[0] = int'(stall0);
            v[1] = i1d.valid; r[1] = i1u.ready; d[1] = i1d.data; s[1] = int'(stall1);
            v[2] = i2d.valid; r[2] = i2u.ready; d[2] = {24'h0, i2d.data}; s[2] = int'(stall2);
            for (int k = 0; k < 3; k++) begin
                logic exp_r, fo, fi;
                logic [31:0] din;
                din   = (k == 2) ? {24'h0, in_data[7:0]} : in_data;
                exp_r = (k == 0) ? (cnt[k] == 0 || out_ready) : (cnt[k] < 2);
                chk($sformatf("rnd_ov%0d", k), v[k], cnt[k] != 0);
                chk($sformatf("rnd_ir%0d", k), r[k], exp_r);
                chk($sformatf("rnd_st%0d", k), s[k], smod[k]);
                fo = cnt[k] != 0 && out_ready;
                fi = in_valid && exp_r;
                if (fo) chk($sformatf("rnd_od%0d", k), d[k], ent[k][0]);
                if (cnt[k] != 0 && !out_ready && smod[k] != ((k == 2) ? 7 : 65535)) smod[k]++;
                if (fo) begin ent[k][0] = ent[k][1]; cnt[k]--; end
                if (fi && !flush) begin ent[k][cnt[k]] = din; cnt[k]++; end
                if (flush) cnt[k] = 0;
            end
            @(posedge clk);
            #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
